alt_mem_ddrx_mm_port_arbiter: RTL
=================================

Name: alt_mem_ddrx_mm_port_arbiter

Overview:
- Shares the single Avalon-MM slave port of the DDR controller's MM-to-ST converter among NUM_PORTS requesters.
- Round-robin arbitration at command boundaries; grant locked for the full length of a write burst.
- Read responses routed back to the issuing port through an in-order tag FIFO.
- Sits between the system interconnect and the controller's Avalon data slave, in ctl_clk domain.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- PORT_ID_WIDTH, 1, clog2(NUM_PORTS), min 1.
- AVL_SIZE_WIDTH, 3, burstcount width.
- AVL_ADDR_WIDTH, 25, word address width.
- AVL_DATA_WIDTH, 32, data width; byte-enable width = AVL_DATA_WIDTH/8.
- TAG_FIFO_DEPTH, 8, maximum outstanding read commands (power of 2).

Ports:
- ctl_clk  in  1  controller clock.
- ctl_reset_n  in  1  asynchronous, active-low reset.
- p_read  in  NUM_PORTS  per-port read request.
- p_write  in  NUM_PORTS  per-port write request.
- p_size  in  NUM_PORTS*AVL_SIZE_WIDTH  per-port burstcount.
- p_addr  in  NUM_PORTS*AVL_ADDR_WIDTH  per-port address.
- p_wdata  in  NUM_PORTS*AVL_DATA_WIDTH  per-port write data.
- p_be  in  NUM_PORTS*AVL_DATA_WIDTH/8  per-port byte enables.
- p_ready  out  NUM_PORTS  per-port wait_n.
- p_rdata_valid  out  NUM_PORTS  per-port read data valid.
- p_rdata  out  AVL_DATA_WIDTH  read data, broadcast to all ports.
- m_ready  in  1  downstream avl_ready.
- m_read_req  out  1  downstream read.
- m_write_req  out  1  downstream write.
- m_size  out  AVL_SIZE_WIDTH  downstream burstcount.
- m_addr  out  AVL_ADDR_WIDTH  downstream address.
- m_wdata  out  AVL_DATA_WIDTH  downstream write data.
- m_be  out  AVL_DATA_WIDTH/8  downstream byte enables.
- m_burstbegin  out  1  high on the first beat of each command.
- m_rdata_valid  in  1  downstream read data valid.
- m_rdata  in  AVL_DATA_WIDTH  downstream read data.
- err_orphan_rdata  out  1  sticky flag: m_rdata_valid arrived with the tag FIFO empty.

Behaviour:
- Reset values:
  - All outputs 0.
  - Round-robin last-grant pointer = NUM_PORTS-1, so port 0 wins first.
  - Tag FIFO empty; FSM in ARB.
- Request vector per port: req[i] = p_read[i] | p_write[i].
- A port with p_read high is masked from req while the tag FIFO is full; its p_read is held with p_ready=0.
- FSM ARB:
  - Grant g is combinational: first requesting port after the last-grant pointer, wrapping.
  - Master outputs mux port g; m_burstbegin=1.
  - p_ready[g] = m_ready; all other p_ready = 0.
  - With no request: m_read_req = m_write_req = 0 and grant is idle.
- Command acceptance: a command is accepted when m_ready & (m_read_req | m_write_req).
  - Read accepted: push {g, size} to the tag FIFO; last-grant <= g; stay in ARB.
  - Write accepted with size<=1: last-grant <= g; stay in ARB.
  - Write accepted with size>1: beat_cnt <= size-1; locked_port <= g; go to WBURST.
- Size 0 is treated as 1 everywhere.
- FSM WBURST:
  - Grant fixed to locked_port; only p_write/p_wdata/p_be of that port pass; m_burstbegin=0; m_read_req forced 0.
  - Each accepted beat decrements beat_cnt.
  - Beat accepted with beat_cnt==1: last-grant <= locked_port; return to ARB.
  - The next command can be granted in the cycle after that beat.
- Reads never interleave inside a write burst.
- Read return path:
  - p_rdata = m_rdata.
  - p_rdata_valid[head.port] = m_rdata_valid, combinational, zero latency.
  - A beat counter counts returned beats against head.size; the FIFO pops on the last beat.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- Orphan data: m_rdata_valid with the FIFO empty is dropped (no p_rdata_valid) and err_orphan_rdata is set; it is cleared only by reset.
- Reset mid-burst: FSM returns to ARB, FIFO is flushed, counters are cleared.

Optional Feature:
- ALT_MEM_DDRX_ARB_FIXED_PRIO_EN defined:
  - ARB uses strict priority: lowest port index wins.
  - Last-grant pointer is removed.
  - Write-burst lock still applies.
- Undefined: round-robin as above.

Decomposition:
- Package alt_mem_ddrx_arb_pkg holds:
  - FSM state encoding (ARB, WBURST).
  - Tag entry struct {port id, size}.
  - Function clog2.
- Sub-module alt_mem_ddrx_arb_tag_fifo:
  - Synchronous FIFO of tag entries.
  - Ports: push, pop, head, full, empty.
  - Same clock and reset.

Test Plan:
- Ports 0 and 1 issue continuous single-beat reads (addr 0x10/0x20), m_ready=1 -> grants alternate 0,1,0,1; FIFO order matches; returned beats route p_rdata_valid to 0,1,0,1.
- Port 1 issues a write of size 4 while port 0 requests a read -> four m_write_req beats from port 1, m_burstbegin only on beat 1; port 0 granted on the cycle after the 4th beat.
- m_ready toggles 1,0,1,0 during a size-4 write -> p_ready[1] tracks m_ready; burst completes after exactly 4 accepted beats.
- TAG_FIFO_DEPTH=8: nine read commands with no returns -> 9th blocked (p_ready=0); after one returned beat of a size-1 read it is accepted the next cycle.
- Assert m_rdata_valid with the FIFO empty -> no p_rdata_valid; err_orphan_rdata=1 until reset.
- With ALT_MEM_DDRX_ARB_FIXED_PRIO_EN, both ports request reads continuously -> port 0 granted every cycle; port 1 starves.

Source files
------------

// File: rtl/alt_mem_ddrx_arb_pkg.sv
// Shared types for the MM port arbiter: FSM encoding, read-tag entry and a clog2 helper.
// Tag fields are sized for the largest supported configuration (8 ports, 8-bit burstcount).
package alt_mem_ddrx_arb_pkg;

  localparam int TAG_PORT_W = 3;
  localparam int TAG_SIZE_W = 8;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    WBURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [TAG_PORT_W-1:0] port;
    logic [TAG_SIZE_W-1:0] size;
  } tag_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) res++;
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/alt_mem_ddrx_mm_port_arbiter_if.sv
// Bundle of requester-side and controller-side Avalon-MM signals around the port arbiter.
// slave = arbiter view, master = view of the surrounding system (requesters + controller).
interface alt_mem_ddrx_mm_port_arbiter_if #(
  parameter int NUM_PORTS      = 2,
  parameter int AVL_SIZE_WIDTH = 3,
  parameter int AVL_ADDR_WIDTH = 25,
  parameter int AVL_DATA_WIDTH = 32
);
  localparam int AVL_BE_WIDTH = AVL_DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]                p_read;
  logic [NUM_PORTS-1:0]                p_write;
  logic [NUM_PORTS*AVL_SIZE_WIDTH-1:0] p_size;
  logic [NUM_PORTS*AVL_ADDR_WIDTH-1:0] p_addr;
  logic [NUM_PORTS*AVL_DATA_WIDTH-1:0] p_wdata;
  logic [NUM_PORTS*AVL_BE_WIDTH-1:0]   p_be;
  logic [NUM_PORTS-1:0]                p_ready;
  logic [NUM_PORTS-1:0]                p_rdata_valid;
  logic [AVL_DATA_WIDTH-1:0]           p_rdata;

  logic                                m_ready;
  logic                                m_read_req;
  logic                                m_write_req;
  logic [AVL_SIZE_WIDTH-1:0]           m_size;
  logic [AVL_ADDR_WIDTH-1:0]           m_addr;
  logic [AVL_DATA_WIDTH-1:0]           m_wdata;
  logic [AVL_BE_WIDTH-1:0]             m_be;
  logic                                m_burstbegin;
  logic                                m_rdata_valid;
  logic [AVL_DATA_WIDTH-1:0]           m_rdata;

  modport slave (
    input  p_read, p_write, p_size, p_addr, p_wdata, p_be,
    output p_ready, p_rdata_valid, p_rdata,
    input  m_ready, m_rdata_valid, m_rdata,
    output m_read_req, m_write_req, m_size, m_addr, m_wdata, m_be, m_burstbegin
  );

  modport master (
    output p_read, p_write, p_size, p_addr, p_wdata, p_be,
    input  p_ready, p_rdata_valid, p_rdata,
    output m_ready, m_rdata_valid, m_rdata,
    input  m_read_req, m_write_req, m_size, m_addr, m_wdata, m_be, m_burstbegin
  );

endinterface

// File: rtl/alt_mem_ddrx_arb_tag_fifo.sv
// In-order FIFO of outstanding read tags {port, size}; DEPTH must be a power of 2.
// push is ignored when full, pop is ignored when empty.
module alt_mem_ddrx_arb_tag_fifo
  import alt_mem_ddrx_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic ctl_clk,
  input  logic ctl_reset_n,
  input  logic push,
  input  tag_t push_data,
  input  logic pop,
  output tag_t head,
  output logic full,
  output logic empty
);
  localparam int AW = clog2(DEPTH);

  tag_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge ctl_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alt_mem_ddrx_mm_port_arbiter.sv
// Shares the controller's single Avalon-MM slave among NUM_PORTS requesters; read data
// is routed back in order via a tag FIFO. ALT_MEM_DDRX_ARB_FIXED_PRIO_EN selects strict priority.
module alt_mem_ddrx_mm_port_arbiter
  import alt_mem_ddrx_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int PORT_ID_WIDTH  = 1,
  parameter int AVL_SIZE_WIDTH = 3,
  parameter int AVL_ADDR_WIDTH = 25,
  parameter int AVL_DATA_WIDTH = 32,
  parameter int TAG_FIFO_DEPTH = 8
) (
  input  logic                           ctl_clk,
  input  logic                           ctl_reset_n,
  alt_mem_ddrx_mm_port_arbiter_if.slave  bus,
  output logic                           err_orphan_rdata
);
  localparam int BE_W = AVL_DATA_WIDTH / 8;

  arb_state_e                state, state_nxt;
  logic [PORT_ID_WIDTH-1:0]  grant, locked_port, sel;
  logic                      grant_vld;
  logic [NUM_PORTS-1:0]      rd_ok, req;
  logic [AVL_SIZE_WIDTH-1:0] beat_cnt;
  logic                      accept, start_burst;
  logic                      fifo_full, fifo_empty, fifo_pop;
  tag_t                      fifo_head;
  logic [TAG_SIZE_W-1:0]     rd_beat_cnt, head_size_eff;
  logic                      rd_beat, rd_last;

  // A blocked read stays off the request vector so it cannot win a grant it could not use.
  assign rd_ok = bus.p_read & {NUM_PORTS{~fifo_full}};
  assign req   = rd_ok | bus.p_write;

`ifdef ALT_MEM_DDRX_ARB_FIXED_PRIO_EN
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = PORT_ID_WIDTH'(i);
        grant_vld = 1'b1;
      end
    end
  end
`else
  logic [PORT_ID_WIDTH-1:0] last_grant;
  logic                     cmd_done;

  // Scanning from the farthest offset down leaves the nearest requester after last_grant.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NUM_PORTS]) begin
        grant     = PORT_ID_WIDTH'((int'(last_grant) + k) % NUM_PORTS);
        grant_vld = 1'b1;
      end
    end
  end

  assign cmd_done = accept & ((state == ARB) ? ~start_burst : (beat_cnt == AVL_SIZE_WIDTH'(1)));

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n)  last_grant <= PORT_ID_WIDTH'(NUM_PORTS - 1);
    else if (cmd_done) last_grant <= sel;
  end
`endif

  always_comb begin
    state_nxt        = state;
    sel              = grant;
    bus.p_ready      = '0;
    bus.m_read_req   = 1'b0;
    bus.m_write_req  = 1'b0;
    bus.m_burstbegin = 1'b0;
    bus.m_size       = '0;
    bus.m_addr       = '0;
    bus.m_wdata      = '0;
    bus.m_be         = '0;
    case (state)
      ARB: begin
        if (grant_vld) begin
          bus.m_write_req  = bus.p_write[grant];
          bus.m_read_req   = rd_ok[grant] & ~bus.p_write[grant];
          bus.m_burstbegin = 1'b1;
          bus.p_ready[grant] = bus.m_ready;
        end
      end
      WBURST: begin
        sel             = locked_port;
        bus.m_write_req = bus.p_write[locked_port];
        bus.p_ready[locked_port] = bus.m_ready;
      end
      default: state_nxt = ARB;
    endcase
    if (bus.m_read_req | bus.m_write_req) begin
      bus.m_size  = bus.p_size[int'(sel)*AVL_SIZE_WIDTH +: AVL_SIZE_WIDTH];
      bus.m_addr  = bus.p_addr[int'(sel)*AVL_ADDR_WIDTH +: AVL_ADDR_WIDTH];
      bus.m_wdata = bus.p_wdata[int'(sel)*AVL_DATA_WIDTH +: AVL_DATA_WIDTH];
      bus.m_be    = bus.p_be[int'(sel)*BE_W +: BE_W];
    end
    if (accept) begin
      if (state == ARB && start_burst)                       state_nxt = WBURST;
      else if (state == WBURST && beat_cnt == AVL_SIZE_WIDTH'(1)) state_nxt = ARB;
    end
  end

  assign accept      = bus.m_ready & (bus.m_read_req | bus.m_write_req);
  assign start_burst = bus.m_write_req & (bus.m_size > AVL_SIZE_WIDTH'(1));

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      state       <= ARB;
      locked_port <= '0;
      beat_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept && state == ARB && start_burst) begin
        locked_port <= grant;
        beat_cnt    <= bus.m_size - 1'b1;
      end else if (accept && state == WBURST) begin
        beat_cnt <= beat_cnt - 1'b1;
      end
    end
  end

  alt_mem_ddrx_arb_tag_fifo #(.DEPTH(TAG_FIFO_DEPTH)) u_tag_fifo (
    .ctl_clk     (ctl_clk),
    .ctl_reset_n (ctl_reset_n),
    .push        (accept & bus.m_read_req),
    .push_data   ('{port: TAG_PORT_W'(grant), size: TAG_SIZE_W'(bus.m_size)}),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign head_size_eff = (fifo_head.size == '0) ? TAG_SIZE_W'(1) : fifo_head.size;
  assign rd_beat       = bus.m_rdata_valid & ~fifo_empty;
  assign rd_last       = (rd_beat_cnt == head_size_eff - 1'b1);
  assign fifo_pop      = rd_beat & rd_last;
  assign bus.p_rdata   = bus.m_rdata;

  always_comb begin
    bus.p_rdata_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      bus.p_rdata_valid[i] = rd_beat & (fifo_head.port == TAG_PORT_W'(i));
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      rd_beat_cnt      <= '0;
      err_orphan_rdata <= 1'b0;
    end else begin
      if (rd_beat) rd_beat_cnt <= rd_last ? '0 : rd_beat_cnt + 1'b1;
      if (bus.m_rdata_valid && fifo_empty) err_orphan_rdata <= 1'b1;
    end
  end

endmodule
